// File: rtl/btn_scan.sv
// Four-button scanner: synchronizes raw board buttons, debounces each one
// independently, and reports a one-hot debounced vector, per-bit press pulses
// and a 2-bit direction code for each clean single-button press.
module btn_scan #(
  parameter int unsigned DB_CYCLES = 100000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn,
  output logic [3:0] press,
  output logic [1:0] code,
  output logic       valid
);

  // Counter value at which a mismatch has lasted DB_CYCLES consecutive cycles.
  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Synchronizer stages.
  logic [3:0] s1_q;
  logic [3:0] s2_q;

  // Debounce state.
  logic [3:0]       db_q;
  logic [3:0]       db_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Previous debounced value, used only for rising-edge detection.
  logic [3:0] db_prev_q;

  // Output registers.
  logic [3:0] btn_q;
  logic [3:0] press_q;
  logic [1:0] code_q;
  logic       valid_q;

  // Derived combinational terms.
  logic [3:0] db_rise;
  logic       db_onehot;
  logic [1:0] db_enc;

  // Two-flop synchronizer; btn_raw is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce next state: any agreement restarts the count, so a bounce
  // shorter than DB_CYCLES never reaches the debounced value.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  // Debounce state registers; channels are independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= 4'b0000;
      db_prev_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db_rise   = db_q & ~db_prev_q;
  assign db_onehot = (db_q != 4'b0000) && ((db_q & (db_q - 4'd1)) == 4'b0000);

  // Direction encoding of the one-hot debounced vector.
  always_comb begin
    db_enc = 2'd0;
    unique case (db_q)
      4'b0001: db_enc = 2'd0;
      4'b0010: db_enc = 2'd1;
      4'b0100: db_enc = 2'd2;
      4'b1000: db_enc = 2'd3;
      default: db_enc = 2'd0;
    endcase
  end

  // Output stage: btn is masked to zero whenever db is not one-hot, and a
  // code update needs both a new press and an unambiguous single button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 4'b0000;
      press_q <= 4'b0000;
      code_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      btn_q   <= db_onehot ? db_q : 4'b0000;
      press_q <= db_rise;
      valid_q <= (db_rise != 4'b0000) && db_onehot;
      if ((db_rise != 4'b0000) && db_onehot) begin
        code_q <= db_enc;
      end
    end
  end

  assign btn   = btn_q;
  assign press = press_q;
  assign code  = code_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_btn_scan.sv
// Directed bench for btn_scan with DB_CYCLES=4: each step queues the expected
// output for every following clock edge, then the edges are run and popped.
module tb_btn_scan;

  localparam int unsigned DbCycles = 4;
  localparam int unsigned CntW     = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn;
  logic [3:0] press;
  logic [1:0] code;
  logic       valid;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] p;
    logic [1:0] c;
    logic       v;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    checks   = 0;
  int    failures = 0;

  btn_scan #(
    .DB_CYCLES (DbCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .btn     (btn),
    .press   (press),
    .code    (code),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue n identical expected output sets, one per upcoming edge.
  task automatic push_n(input int n, input string tag, input logic [3:0] b,
                        input logic [3:0] p, input logic [1:0] c, input logic v);
    exp_t e;
    e.b = b;
    e.p = p;
    e.c = c;
    e.v = v;
    for (int i = 0; i < n; i++) begin
      sb.push_back(e);
      sb_tag.push_back(tag);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    checks++;
    assert ({btn, press, code, valid} === e)
    else begin
      failures++;
      $error("FAIL %s: btn/press/code/valid got %b/%b/%b/%b expected %b/%b/%b/%b",
             tag, btn, press, code, valid, e.b, e.p, e.c, e.v);
    end
  endtask

  // One edge per queued entry; outputs sampled 1 ns after the rising edge.
  task automatic run_pop();
    exp_t  e;
    string t;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      t = sb_tag.pop_front();
      compare(t, e);
    end
  endtask

  // Check outputs right now, with no clock edge involved.
  task automatic check_now(input string tag, input logic [3:0] b, input logic [3:0] p,
                           input logic [1:0] c, input logic v);
    exp_t e;
    e.b = b;
    e.p = p;
    e.c = c;
    e.v = v;
    compare(tag, e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'b0001;
    #2;
    check_now("reset_async", 4'b0000, 4'b0000, 2'd0, 1'b0);
    push_n(2, "reset_held", 4'b0000, 4'b0000, 2'd0, 1'b0);
    run_pop();

    // Single press of "up": appears on edge 7 after release.
    rst_n = 1'b1;
    push_n(6, "up_wait", 4'b0000, 4'b0000, 2'd0, 1'b0);
    push_n(1, "up_press", 4'b0001, 4'b0001, 2'd0, 1'b1);
    push_n(2, "up_hold", 4'b0001, 4'b0000, 2'd0, 1'b0);
    run_pop();

    // Release "up".
    btn_raw = 4'b0000;
    push_n(6, "up_rel_wait", 4'b0001, 4'b0000, 2'd0, 1'b0);
    push_n(2, "up_released", 4'b0000, 4'b0000, 2'd0, 1'b0);
    run_pop();

    // Three-cycle glitch on "down" must not get through.
    btn_raw = 4'b0100;
    push_n(3, "glitch_hi", 4'b0000, 4'b0000, 2'd0, 1'b0);
    run_pop();
    btn_raw = 4'b0000;
    push_n(8, "glitch_lo", 4'b0000, 4'b0000, 2'd0, 1'b0);
    run_pop();

    // "right" held: code 01 with valid.
    btn_raw = 4'b0010;
    push_n(6, "right_wait", 4'b0000, 4'b0000, 2'd0, 1'b0);
    push_n(1, "right_press", 4'b0010, 4'b0010, 2'd1, 1'b1);
    push_n(2, "right_hold", 4'b0010, 4'b0000, 2'd1, 1'b0);
    run_pop();

    // "left" added while "right" held: press but no valid, btn masked.
    btn_raw = 4'b1010;
    push_n(6, "left_add_wait", 4'b0010, 4'b0000, 2'd1, 1'b0);
    push_n(1, "left_add_press", 4'b0000, 4'b1000, 2'd1, 1'b0);
    push_n(2, "multi_hold", 4'b0000, 4'b0000, 2'd1, 1'b0);
    run_pop();

    // Release "right": btn returns to left, no press, no valid.
    btn_raw = 4'b1000;
    push_n(6, "right_rel_wait", 4'b0000, 4'b0000, 2'd1, 1'b0);
    push_n(2, "left_only", 4'b1000, 4'b0000, 2'd1, 1'b0);
    run_pop();

    // Release all.
    btn_raw = 4'b0000;
    push_n(6, "all_rel_wait", 4'b1000, 4'b0000, 2'd1, 1'b0);
    push_n(2, "all_released", 4'b0000, 4'b0000, 2'd1, 1'b0);
    run_pop();

    // Simultaneous "down"+"left".
    btn_raw = 4'b1100;
    push_n(6, "dual_wait", 4'b0000, 4'b0000, 2'd1, 1'b0);
    push_n(1, "dual_press", 4'b0000, 4'b1100, 2'd1, 1'b0);
    push_n(2, "dual_hold", 4'b0000, 4'b0000, 2'd1, 1'b0);
    run_pop();
    btn_raw = 4'b0000;
    push_n(8, "dual_release", 4'b0000, 4'b0000, 2'd1, 1'b0);
    run_pop();

    // Reset at edge 3 of a "down" debounce discards progress.
    btn_raw = 4'b0100;
    push_n(3, "down_pre_rst", 4'b0000, 4'b0000, 2'd1, 1'b0);
    run_pop();
    rst_n = 1'b0;
    #1;
    check_now("mid_reset_async", 4'b0000, 4'b0000, 2'd0, 1'b0);
    push_n(1, "mid_reset_held", 4'b0000, 4'b0000, 2'd0, 1'b0);
    run_pop();
    rst_n = 1'b1;
    push_n(6, "down_post_rst_wait", 4'b0000, 4'b0000, 2'd0, 1'b0);
    push_n(1, "down_press", 4'b0100, 4'b0100, 2'd2, 1'b1);
    push_n(2, "down_hold", 4'b0100, 4'b0000, 2'd2, 1'b0);
    run_pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_scan.md
BTN_SCAN -- requirements
Module: btn_scan

Interface
- REQ-001: Parameter DB_CYCLES, default 100000: consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates; legal range 2..2^CNT_W-1.
- REQ-002: Parameter CNT_W, default 17: width of each per-bit debounce counter.
- REQ-003: clk  input  1  system clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: btn_raw  input  4  raw board buttons, active-high, asynchronous to clk; bit0=up, bit1=right, bit2=down, bit3=left.
- REQ-006: btn  output  4  registered debounced button vector; exactly one-hot or 4'b0000, never multi-hot.
- REQ-007: press  output  4  registered one-cycle pulse per bit on a debounced 0->1 transition.
- REQ-008: code  output  2  registered direction code of the most recent valid single press: bit0->00, bit1->01, bit2->10, bit3->11.
- REQ-009: valid  output  1  registered one-cycle strobe, asserted in the same cycle that code updates.

Function
- REQ-010: Each btn_raw bit shall pass through a 2-flop synchronizer (s1, s2) before any other logic.
- REQ-011: Each bit shall hold a debounced value db[i] and a counter cnt[i].
- REQ-012: If s2[i]==db[i], cnt[i] shall clear to 0 on the next edge.
- REQ-013: If s2[i]!=db[i] and cnt[i]<DB_CYCLES-1, cnt[i] shall increment.
- REQ-014: If s2[i]!=db[i] and cnt[i]==DB_CYCLES-1, db[i] shall take s2[i] and cnt[i] shall clear.
- REQ-015: A mismatch lasting fewer than DB_CYCLES consecutive cycles (glitch, bounce) shall leave db[i] unchanged and restart the count.
- REQ-016: btn shall register db when db has exactly one bit set, else 4'b0000.
- REQ-017: press[i] shall be 1 for exactly one cycle, registered one edge after db[i] rises; no pulse on a fall.
- REQ-018: Latency: a clean btn_raw step held steady shall appear on btn/press exactly DB_CYCLES+3 rising edges after the first edge sampling it.
- REQ-019: When press is nonzero and the new db is one-hot, code shall update to the encoded bit and valid shall pulse in the same cycle as press.
- REQ-020: If press fires while the new db is multi-hot (simultaneous presses, or a second button pressed while one is held), press still pulses, btn shall be 0, and code/valid shall be unchanged/0.
- REQ-021: Releasing buttons so that db returns to one-hot shall restore btn to that bit with no press and no valid.
- REQ-022: code shall hold its value between valid strobes, including while btn is 0.
- REQ-023: The four bit channels shall operate independently; counters do not interact.

Reset
- REQ-024: While rst_n==0, s1, s2, db, cnt, btn, press, code and valid shall be 0, independent of clk.
- REQ-025: Assertion of reset mid-count or mid-press shall discard all progress; after release, every bit needs a full DB_CYCLES of stable input before any change.
- REQ-026: A button held through reset release shall produce a press pulse DB_CYCLES+3 edges after release.

Verification (DB_CYCLES=4)
- REQ-027: Reset, btn_raw=0001 steady -> btn=0001, press=0001 (1 cycle), code=00, valid=1 at edge 7; btn holds 0001.
- REQ-028: btn_raw=0100 pulsed high for 3 cycles then low -> btn, press, valid stay 0; code unchanged.
- REQ-029: btn_raw=0010 held, then 1000 added -> first code=01/valid; after the second debounce btn=0000, press=1000, valid=0, code stays 01; releasing 0010 -> btn=1000, no press/valid.
- REQ-030: btn_raw goes 0000->1100 in a single cycle -> press=1100 for one cycle, btn=0000, valid=0.
- REQ-031: rst_n pulsed low at edge 3 of a 0100 debounce -> all outputs 0 immediately; with 0100 held, btn=0100/code=10 exactly 7 edges after rst_n release.
